fetch_mem_arbiter: RTL

Arbitrates a single shared RAM port between the fetch stage's instruction request channel and the memory stage's data request channel. It sits between the fetch/memory stages and the RAM model, serializes one transaction at a time, and returns per-requester hit pulses. Data requests take priority; an optional starvation guard forces an instruction grant after repeated data wins.

---
 rtl/fetch_mem_arbiter_if.sv | 33 +++
 rtl/fetch_mem_arbiter.sv | 113 +++++++++++
 2 files changed

// File: rtl/fetch_mem_arbiter_if.sv
// Bundle of fetch/memory request channels and shared RAM port signals for fetch_mem_arbiter.
// slave is the arbiter's view; master is the stages-plus-RAM side.
interface fetch_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              iREN;
  logic [ADDR_W-1:0] iaddr;
  logic              ihit;
  logic [DATA_W-1:0] iload;
  logic              dREN;
  logic              dWEN;
  logic [ADDR_W-1:0] daddr;
  logic [DATA_W-1:0] dstore;
  logic              dhit;
  logic [DATA_W-1:0] dload;
  logic              ramREN;
  logic              ramWEN;
  logic [ADDR_W-1:0] ramaddr;
  logic [DATA_W-1:0] ramstore;
  logic [DATA_W-1:0] ramload;
  logic              ram_ready;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ram_ready,
    output ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ram_ready,
    input  ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/fetch_mem_arbiter.sv
// Shares one RAM port between instruction fetch and data memory requests, data first.
// Define FETCH_MEM_ARB_STARVE_EN to add the instruction starvation guard (STARVE_MAX).
module fetch_mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input logic                CLK,
  input logic                nRST,
  fetch_mem_arbiter_if.slave io_arb
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IACC = 2'd1,
    DACC = 2'd2,
    TURN = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic              w_grantI;
  logic              w_grantD;
  logic              w_reqD;
  logic              w_forceI;
  logic              w_inAcc;
  logic              r_ren;
  logic              r_wen;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_store;

  assign w_reqD = io_arb.dREN | io_arb.dWEN;

`ifdef FETCH_MEM_ARB_STARVE_EN
  localparam int CW = $clog2(STARVE_MAX + 1);

  logic [CW-1:0] r_starve;

  assign w_forceI = io_arb.iREN && (r_starve == CW'(STARVE_MAX));

  // Counts data wins while a fetch waits; resets once fetch is served or stops asking.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_starve <= '0;
    end else if (w_grantI || (r_state == IDLE && !io_arb.iREN)) begin
      r_starve <= '0;
    end else if (w_grantD && io_arb.iREN) begin
      r_starve <= r_starve + CW'(1);
    end
  end
`else
  assign w_forceI = 1'b0;
`endif

  always_comb begin
    w_next   = r_state;
    w_grantI = 1'b0;
    w_grantD = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_forceI) begin
          w_grantI = 1'b1;
          w_next   = IACC;
        end else if (w_reqD) begin
          w_grantD = 1'b1;
          w_next   = DACC;
        end else if (io_arb.iREN) begin
          w_grantI = 1'b1;
          w_next   = IACC;
        end
      end
      IACC:    if (io_arb.ram_ready) w_next = TURN;
      DACC:    if (io_arb.ram_ready) w_next = TURN;
      TURN:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Access parameters are frozen at grant so a squashed requester cannot disturb the RAM.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= IDLE;
      r_ren   <= 1'b0;
      r_wen   <= 1'b0;
      r_addr  <= '0;
      r_store <= '0;
    end else begin
      r_state <= w_next;
      if (w_grantI) begin
        r_ren  <= 1'b1;
        r_wen  <= 1'b0;
        r_addr <= io_arb.iaddr;
      end else if (w_grantD) begin
        r_ren   <= io_arb.dREN;
        r_wen   <= io_arb.dWEN;
        r_addr  <= io_arb.daddr;
        r_store <= io_arb.dstore;
      end
    end
  end

  assign w_inAcc = (r_state == IACC) || (r_state == DACC);

  assign io_arb.ramREN   = w_inAcc & r_ren;
  assign io_arb.ramWEN   = w_inAcc & r_wen;
  assign io_arb.ramaddr  = r_addr;
  assign io_arb.ramstore = r_store;
  assign io_arb.ihit     = (r_state == IACC) & io_arb.ram_ready & io_arb.iREN;
  assign io_arb.dhit     = (r_state == DACC) & io_arb.ram_ready & w_reqD;
  assign io_arb.iload    = io_arb.ramload;
  assign io_arb.dload    = io_arb.ramload;

endmodule
